dcpu_intctl: RTL and testbench

DCPU_INTCTL -- requirements
Module: dcpu_intctl

---
 rtl/dcpu_intctl.sv | 185 ++++++++++++++++++
 tb/tb_dcpu_intctl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu_intctl.sv
// dcpu_intctl: interrupt controller for the DCPU.
// Synchronises NSRC asynchronous request lines and latches them as edge- or
// level-sensitive pending bits. It exposes PENDING / ENABLE / MODE / VECTOR
// registers and drives a registered interrupt request to the CPU. A VECTOR
// read claims the lowest-numbered enabled pending source.
module dcpu_intctl #(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [NSRC-1:0] i_irq,
  input  logic            i_cs,
  input  logic [15:0]     i_addr,
  input  logic            i_rw,
  input  logic [15:0]     i_dat,
  output logic [15:0]     o_dat,
  output logic            o_int
);

  // Register map selected by i_addr[2:1].
  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_MODE    = 2'd2,
    REG_VECTOR  = 2'd3
  } reg_sel_e;

  // The fill counter saturates one edge after the synchroniser output first
  // carries a real sample. From then on, the edge history holds a real sample
  // too.
  localparam logic [2:0] FILL_MAX = 3'(SYNC_STAGES + 1);

  // Synchroniser chain: stage 0 samples i_irq, and the last stage is sync.
  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q, sync_d;
  logic [NSRC-1:0]                  sync;

  // Edge-detect history (sync one cycle earlier) and its validity counter.
  logic [NSRC-1:0] hist_q, hist_d;
  logic [2:0]      fill_q, fill_d;
  logic            hist_valid;
  logic [NSRC-1:0] rise;

  // Programmer-visible state.
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic            int_q, int_d;

  // Bus decode.
  reg_sel_e        reg_sel;
  logic            wr_en;
  logic            rd_en;

  // Priority/claim datapath.
  logic [NSRC-1:0] active;
  logic            vec_valid;
  logic [3:0]      vec_idx;
  logic [15:0]     vector;
  logic            claim;
  logic [NSRC-1:0] claim_mask;
  logic [NSRC-1:0] w1c_mask;
  logic [NSRC-1:0] mode_chg;

  // Address and data bits outside the register map are deliberately ignored.
  logic            unused_bits;
  assign unused_bits = ^{i_addr[15:3], i_addr[0], i_dat[15:NSRC]};

  assign reg_sel = reg_sel_e'(i_addr[2:1]);
  assign wr_en   = i_cs & ~i_rw;
  assign rd_en   = i_cs & i_rw;
  assign sync    = sync_q[SYNC_STAGES-1];

  // Shift the synchroniser, track edge history and count post-reset fill.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], i_irq};
    hist_d     = sync;
    fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + 3'd1;
    hist_valid = (fill_q == FILL_MAX);
    // A rise needs a real low sample in the history. Reset zeros do not count,
    // so a line held high across reset never looks like an edge.
    rise       = sync & ~hist_q & {NSRC{hist_valid}};
  end

  // Synchroniser, history and fill counter flops.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '0;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  // Lowest-numbered enabled pending source wins the vector.
  always_comb begin
    active    = pending_q & enable_q;
    vec_valid = 1'b0;
    vec_idx   = 4'd0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (active[k]) begin
        vec_valid = 1'b1;
        vec_idx   = 4'(k);
      end
    end
    vector = {vec_valid, 11'b0, vec_idx};
  end

  // Derive the per-source clear/change masks for the current bus cycle.
  always_comb begin
    claim    = rd_en && (reg_sel == REG_VECTOR) && vec_valid;
    w1c_mask = (wr_en && (reg_sel == REG_PENDING)) ? i_dat[NSRC-1:0] : '0;
    mode_chg = (wr_en && (reg_sel == REG_MODE)) ? (i_dat[NSRC-1:0] ^ mode_q) : '0;
    claim_mask = '0;
    for (int k = 0; k < NSRC; k++) begin
      claim_mask[k] = claim && (vec_idx == 4'(k));
    end
  end

  // Next state of pending, enable and mode, plus the interrupt request.
  always_comb begin
    pending_d = pending_q;
    for (int k = 0; k < NSRC; k++) begin
      if (mode_chg[k]) begin
        // Switching a source's sensitivity discards whatever it had latched.
        pending_d[k] = 1'b0;
      end else if (!mode_q[k]) begin
        // Level sources mirror the synchronised line; clears do not apply.
        pending_d[k] = sync[k];
      end else if (rise[k]) begin
        // A new edge beats a simultaneous W1C or claim.
        pending_d[k] = 1'b1;
      end else if (w1c_mask[k] || claim_mask[k]) begin
        pending_d[k] = 1'b0;
      end
    end

    enable_d = enable_q;
    if (wr_en && (reg_sel == REG_ENABLE)) begin
      enable_d = i_dat[NSRC-1:0];
    end

    mode_d = mode_q;
    if (wr_en && (reg_sel == REG_MODE)) begin
      mode_d = i_dat[NSRC-1:0];
    end

    int_d = |active;
  end

  // Register-file and interrupt-request flops.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      int_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      int_q     <= int_d;
    end
  end

  // Combinational read mux; returns zero whenever no read is in progress.
  always_comb begin
    o_dat = 16'h0000;
    if (rd_en) begin
      case (reg_sel)
        REG_PENDING: o_dat = {{(16-NSRC){1'b0}}, pending_q};
        REG_ENABLE:  o_dat = {{(16-NSRC){1'b0}}, enable_q};
        REG_MODE:    o_dat = {{(16-NSRC){1'b0}}, mode_q};
        REG_VECTOR:  o_dat = vector;
        default:     o_dat = 16'h0000;
      endcase
    end
  end

  assign o_int = int_q;

endmodule

// File: tb/tb_dcpu_intctl.sv
// Testbench for dcpu_intctl.
// It runs a register-access vector table, then hand sequences for the
// multi-cycle corner cases, then randomized traffic checked against a
// queue-based reference model.
module tb_dcpu_intctl;
  localparam int NSRC = 8;
  localparam int SS   = 2;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NSRC-1:0] irq   = '0;
  logic            cs    = 1'b0;
  logic            rw    = 1'b1;
  logic [15:0]     addr  = 16'h0;
  logic [15:0]     dat   = 16'h0;
  logic [15:0]     o_dat;
  logic            o_int;

  int n_pass = 0;
  int n_chk  = 0;

  dcpu_intctl #(.NSRC(NSRC), .SYNC_STAGES(SS)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_irq    (irq),
    .i_cs     (cs),
    .i_addr   (addr),
    .i_rw     (rw),
    .i_dat    (dat),
    .o_dat    (o_dat),
    .o_int    (o_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] dat;
    logic [15:0] exp_dat;
    logic        exp_int;
    string       name;
  } vec_t;

  vec_t tbl[14];

  // ---------------- reference model ----------------
  logic [NSRC-1:0] m_pend, m_en, m_mode;
  logic            m_int;
  logic [NSRC-1:0] m_samp[$];   // i_irq as sampled at each edge since reset

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp, input bit verbose);
    n_chk++;
    if (act === exp) begin
      n_pass++;
      if (verbose) $display("  %s: 0x%04h ok", name, act);
    end else begin
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_int = 1'b0;
    m_samp.delete();
  endtask

  function automatic logic [15:0] m_read();
    logic [15:0] r;
    r = 16'h0;
    if (cs && rw) begin
      case (addr[2:1])
        2'd0: r = 16'(m_pend);
        2'd1: r = 16'(m_en);
        2'd2: r = 16'(m_mode);
        default: begin
          for (int k = 0; k < NSRC; k++) begin
            if (m_pend[k] && m_en[k]) begin
              r = 16'h8000 | 16'(k);
              break;
            end
          end
        end
      endcase
    end
    return r;
  endfunction

  // Advance the model across one rising edge using the current bus/irq inputs.
  task automatic model_step();
    logic [NSRC-1:0] sync, prev_low, rise, nxt, act;
    int  sz, idx;
    bit  valid, wr, rd;
    sz   = m_samp.size();
    // The line seen now was sampled SS edges ago; before that the chain holds zeros.
    sync = (sz >= SS) ? m_samp[sz-SS] : '0;
    // An edge needs the previous cycle's value to be a real low sample.
    prev_low = (sz >= SS + 1) ? ~m_samp[sz-SS-1] : '0;
    rise = sync & prev_low;
    act  = m_pend & m_en;
    valid = 0; idx = 0;
    for (int k = 0; k < NSRC; k++) if (act[k] && !valid) begin valid = 1; idx = k; end
    wr = cs && !rw;
    rd = cs && rw;
    nxt = m_pend;
    for (int k = 0; k < NSRC; k++) begin
      if (wr && addr[2:1] == 2'd2 && dat[k] != m_mode[k]) nxt[k] = 1'b0;
      else if (!m_mode[k]) nxt[k] = sync[k];
      else if (rise[k]) nxt[k] = 1'b1;
      else if ((wr && addr[2:1] == 2'd0 && dat[k]) ||
               (rd && addr[2:1] == 2'd3 && valid && idx == k)) nxt[k] = 1'b0;
    end
    m_int = |act;
    if (wr && addr[2:1] == 2'd1) m_en   = dat[NSRC-1:0];
    if (wr && addr[2:1] == 2'd2) m_mode = dat[NSRC-1:0];
    m_pend = nxt;
    m_samp.push_back(irq);
    if (m_samp.size() > 8) void'(m_samp.pop_front());
  endtask

  // ---------------- bus helpers (called at negedge) ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] r, output logic [15:0] v);
    cs = 1'b1; rw = 1'b1; addr = {13'h0, r, 1'b0};
    #1 v = o_dat;
    cyc();
    cs = 1'b0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [15:0] d);
    cs = 1'b1; rw = 1'b0; addr = {13'h0, r, 1'b0}; dat = d;
    cyc();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic chk_rd(input string name, input logic [1:0] r, input logic [15:0] exp);
    logic [15:0] v;
    rd(r, v);
    check(name, v, exp, 1'b1);
  endtask

  task automatic chk_int(input string name, input logic exp);
    #1 check(name, {15'h0, o_int}, {15'h0, exp}, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, "rst_pending"};
    tbl[1]  = '{1'b1, 1'b1, 16'h0002, 16'h0000, 16'h0000, 1'b0, "rst_enable"};
    tbl[2]  = '{1'b1, 1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b0, "rst_mode"};
    tbl[3]  = '{1'b1, 1'b1, 16'h0006, 16'h0000, 16'h0000, 1'b0, "rst_vector"};
    tbl[4]  = '{1'b1, 1'b0, 16'h0002, 16'hFFFF, 16'h0000, 1'b0, "wr_enable"};
    tbl[5]  = '{1'b1, 1'b1, 16'hF003, 16'h0000, 16'h00FF, 1'b0, "enable_masked"};
    tbl[6]  = '{1'b1, 1'b0, 16'h0004, 16'h12A5, 16'h0000, 1'b0, "wr_mode"};
    tbl[7]  = '{1'b1, 1'b1, 16'h0004, 16'h0000, 16'h00A5, 1'b0, "mode_masked"};
    tbl[8]  = '{1'b1, 1'b0, 16'h0006, 16'hFFFF, 16'h0000, 1'b0, "wr_vector"};
    tbl[9]  = '{1'b1, 1'b1, 16'h0006, 16'h0000, 16'h0000, 1'b0, "vector_ro"};
    tbl[10] = '{1'b0, 1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b0, "no_cs"};
    tbl[11] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b0, "clr_enable"};
    tbl[12] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0, "clr_mode"};
    tbl[13] = '{1'b1, 1'b1, 16'h0002, 16'h0000, 16'h0000, 1'b0, "enable_cleared"};

    // Values seen while reset is held.
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; addr = 16'h0006;
    #1 check("in_reset_vector", o_dat, 16'h0000, 1'b1);
    check("in_reset_int", {15'h0, o_int}, 16'h0000, 1'b1);
    cs = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (5) cyc();

    // Register-access vector table.
    for (int i = 0; i < 14; i++) begin
      cs = tbl[i].cs; rw = tbl[i].rw; addr = tbl[i].addr; dat = tbl[i].dat;
      #1;
      check({tbl[i].name, "_dat"}, o_dat, tbl[i].exp_dat, 1'b1);
      check({tbl[i].name, "_int"}, {15'h0, o_int}, {15'h0, tbl[i].exp_int}, 1'b0);
      cyc();
    end
    cs = 1'b0; rw = 1'b1;

    // Edge-mode pulse latency, vector and claim.
    wr(2'd2, 16'h0001);
    wr(2'd1, 16'h0001);
    irq[0] = 1'b1;
    cyc();                        // edge 1 samples the request
    irq[0] = 1'b0;
    cyc();
    cyc();
    chk_int("edge_int_e3", 1'b0);
    cyc();
    chk_int("edge_int_e4", 1'b1);
    chk_rd("edge_pending", 2'd0, 16'h0001);
    chk_rd("edge_vector", 2'd3, 16'h8000);
    cyc();
    chk_int("edge_int_after_claim", 1'b0);
    chk_rd("edge_pending_claimed", 2'd0, 16'h0000);

    // Priority between two edge sources with successive claims.
    wr(2'd2, 16'h00FF);
    wr(2'd1, 16'h00FF);
    irq[5] = 1'b1; irq[2] = 1'b1;
    repeat (5) cyc();
    chk_rd("prio_vec1", 2'd3, 16'h8002);
    chk_rd("prio_vec2", 2'd3, 16'h8005);
    chk_rd("prio_vec3", 2'd3, 16'h0000);
    chk_int("prio_int_low", 1'b0);
    irq = '0;

    // Level mode ignores claims and W1C; o_int tracks the line.
    wr(2'd2, 16'h0000);
    wr(2'd1, 16'h0008);
    irq[3] = 1'b1;
    repeat (5) cyc();
    chk_rd("level_vec1", 2'd3, 16'h8003);
    chk_rd("level_vec2", 2'd3, 16'h8003);
    wr(2'd0, 16'h0008);
    chk_rd("level_vec3", 2'd3, 16'h8003);
    chk_rd("level_pending", 2'd0, 16'h0008);
    irq[3] = 1'b0;
    cyc();
    cyc();
    cyc();
    chk_int("level_int_e3", 1'b1);
    cyc();
    chk_int("level_int_e4", 1'b0);

    // Set/clear race: W1C lands on the edge where the rise is latched.
    wr(2'd2, 16'h0002);
    wr(2'd1, 16'h0002);
    irq[1] = 1'b1;
    cyc();
    cyc();
    wr(2'd0, 16'h0002);
    chk_rd("race_pending", 2'd0, 16'h0002);
    wr(2'd0, 16'h0002);
    chk_rd("w1c_pending", 2'd0, 16'h0000);
    irq[1] = 1'b0;

    // Masking: pending but disabled.
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0010);
    irq[4] = 1'b1;
    cyc();
    irq[4] = 1'b0;
    repeat (4) cyc();
    chk_int("mask_int", 1'b0);
    chk_rd("mask_vector", 2'd3, 16'h0000);
    chk_rd("mask_pending", 2'd0, 16'h0010);
    wr(2'd1, 16'h0010);
    chk_int("unmask_int_same", 1'b0);
    cyc();
    chk_int("unmask_int_next", 1'b1);

    // Asynchronous reset mid-cycle with o_int high and a line held high.
    irq[6] = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_int", {15'h0, o_int}, 16'h0000, 1'b1);
    @(negedge clk);
    chk_rd("rst_rd_pending", 2'd0, 16'h0000);
    chk_rd("rst_rd_enable", 2'd1, 16'h0000);
    chk_rd("rst_rd_mode", 2'd2, 16'h0000);
    chk_rd("rst_rd_vector", 2'd3, 16'h0000);
    rst_n = 1'b1;
    wr(2'd2, 16'h0040);           // edge mode before the chain has filled
    wr(2'd1, 16'h0040);
    repeat (4) cyc();
    chk_rd("held_high_pending", 2'd0, 16'h0000);
    chk_int("held_high_int", 1'b0);
    irq[6] = 1'b0;
    repeat (3) cyc();
    irq[6] = 1'b1;
    repeat (5) cyc();
    chk_rd("fresh_edge_pending", 2'd0, 16'h0040);
    irq = '0;

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    cyc();
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      irq  = irq ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
      cs   = ($urandom_range(0, 3) != 0);
      rw   = 1'($urandom_range(0, 1));
      addr = 16'($urandom);
      dat  = 16'($urandom);
      #1;
      check($sformatf("rand_dat c%0d", c), o_dat, m_read(), 1'b0);
      check($sformatf("rand_int c%0d", c), {15'h0, o_int}, {15'h0, m_int}, 1'b0);
      model_step();
      cyc();
    end
    cs = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
